bsg_link_upstream_refine_monitor: RTL and testbench

//  Parametrised checker for the DDR link upstream path, for formal and simulation benches.

---
 rtl/bsg_link_upstream_refine_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_bsg_link_upstream_refine_monitor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_upstream_refine_monitor.sv
// Upstream DDR link checker: follows core handshakes, per-channel credits and
// token returns, and confirms every accepted core word leaves on the io
// channels as an ordered pair of half-beats. Errors are sticky until clear_i.
//
// state | meaning
// IDLE  | waiting for the first (phase 0) half-beat of the word at FIFO head
// HALF  | first half-beat seen, second (phase 1) half-beat due this cycle
module bsg_link_upstream_refine_monitor #(
  parameter int NUM_CH    = 2,
  parameter int CH_WIDTH  = 8,
  parameter int CREDITS   = 64,
  parameter int TOKEN_DEC = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_LAT   = 10,
  localparam int W  = 2*NUM_CH*CH_WIDTH,
  localparam int CW = $clog2(CREDITS)+1,
  localparam int PW = $clog2(DEPTH)+1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     core_valid_i,
  input  logic                     core_ready_i,
  input  logic [W-1:0]             core_data_i,
  input  logic [NUM_CH-1:0]        io_valid_i,
  input  logic                     io_phase_i,
  input  logic [NUM_CH*CH_WIDTH-1:0] io_data_i,
  input  logic [NUM_CH-1:0]        token_i,
  output logic [CW-1:0]            sent_cnt_o,
  output logic [NUM_CH*CW-1:0]     finish_cnt_o,
  output logic [NUM_CH*CW-1:0]     outstanding_o,
  output logic [PW-1:0]            pending_o,
  output logic [1:0]               state_o,
  output logic                     beat_ok_o,
  output logic                     err_overflow_o,
  output logic                     err_credit_o,
  output logic                     err_data_o,
  output logic                     err_lockstep_o,
  output logic                     err_timeout_o,
  output logic                     err_any_o
);

  localparam int HW = NUM_CH*CH_WIDTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // age saturates one past the firing value so a timeout fires only once per head
  localparam int LW = $clog2(MAX_LAT+3);
  localparam logic [CW-1:0] TOK_INC  = CW'(TOKEN_DEC);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [LW-1:0] LAT_OVER = LW'(MAX_LAT+1);
  localparam logic [LW-1:0] LAT_SAT  = LW'(MAX_LAT+2);

  typedef enum logic [1:0] {IDLE = 2'd0, HALF = 2'd1} state_t;

  state_t                     state, state_nxt;
  logic                       half_ok, half_ok_nxt;
  logic [CW-1:0]              sent_cnt;
  logic [NUM_CH-1:0][CW-1:0]  finish_cnt;
  logic [NUM_CH-1:0][CW-1:0]  outstanding;
  logic [W-1:0]               mem [DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr, count;
  logic [LW-1:0]              age, age_nxt;
  logic [4:0]                 err_flags, err_set;
  logic                       beat_ok, beat;
  logic                       hs, all_v, any_v, empty, full, push, pop;
  logic                       match_lo, match_hi, data_err, credit_err;
  logic [W-1:0]               head;

  assign hs       = core_valid_i & core_ready_i;
  assign all_v    = &io_valid_i;
  assign any_v    = |io_valid_i;
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == PW'(DEPTH));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign match_lo = (io_data_i == head[HW-1:0]);
  assign match_hi = (io_data_i == head[W-1:HW]);
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push     = hs & (~full | pop);

  // per-channel outstanding credits from the registered counters
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) outstanding[c] = sent_cnt - finish_cnt[c];
  end

  // credit violations judged on pre-update counter values
  always_comb begin
    credit_err = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs && outstanding[c] == CRED_MAX) credit_err = 1'b1;
      if (token_i[c] && outstanding[c] < TOK_INC) credit_err = 1'b1;
    end
  end

  // half-beat sequencing: next state, pop and data check
  always_comb begin
    state_nxt   = state;
    half_ok_nxt = half_ok;
    pop         = 1'b0;
    data_err    = 1'b0;
    beat        = 1'b0;
    case (state)
      IDLE: begin
        if (all_v) begin
          if (empty || io_phase_i) begin
            data_err = 1'b1;
          end else begin
            state_nxt   = HALF;
            half_ok_nxt = match_lo;
            data_err    = ~match_lo;
          end
        end
      end
      HALF: begin
        pop       = 1'b1;
        state_nxt = IDLE;
        if (all_v && io_phase_i) begin
          beat     = half_ok & match_hi;
          data_err = ~match_hi;
        end else begin
          data_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // head-age tracking, cleared whenever the head leaves or the FIFO is empty
  always_comb begin
    age_nxt = age;
    if (pop || empty) age_nxt = '0;
    else if (age != LAT_SAT) age_nxt = age + LW'(1);
  end

  assign err_set = {age == LAT_OVER,
                    any_v & ~all_v,
                    data_err,
                    credit_err,
                    hs & full & ~pop};

  // FSM, age and beat pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      half_ok <= 1'b0;
      age     <= '0;
      beat_ok <= 1'b0;
    end else begin
      state   <= state_nxt;
      half_ok <= half_ok_nxt;
      age     <= age_nxt;
      beat_ok <= beat;
    end
  end

  // handshake and token counters, wrapping at their width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt   <= '0;
      finish_cnt <= '0;
    end else begin
      if (hs) sent_cnt <= sent_cnt + CW'(1);
      for (int c = 0; c < NUM_CH; c++)
        if (token_i[c]) finish_cnt[c] <= finish_cnt[c] + TOK_INC;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= core_data_i;
  end

  // sticky error flags; a set wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_flags <= '0;
    else     err_flags <= (err_flags & ~{5{clear_i}}) | err_set;
  end

  assign sent_cnt_o     = sent_cnt;
  assign finish_cnt_o   = finish_cnt;
  assign outstanding_o  = outstanding;
  assign pending_o      = count;
  assign state_o        = state;
  assign beat_ok_o      = beat_ok;
  assign err_overflow_o = err_flags[0];
  assign err_credit_o   = err_flags[1];
  assign err_data_o     = err_flags[2];
  assign err_lockstep_o = err_flags[3];
  assign err_timeout_o  = err_flags[4];
  assign err_any_o      = |err_flags;

endmodule

// File: tb/tb_bsg_link_upstream_refine_monitor.sv
// Bench for bsg_link_upstream_refine_monitor: directed scenarios plus random
// traffic, checked against a queue-based reference model and a beat scoreboard.
module tb_bsg_link_upstream_refine_monitor;

  localparam int NUM_CH = 2, CH_WIDTH = 8, CREDITS = 64, TOKEN_DEC = 8;
  localparam int DEPTH = 4, MAX_LAT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        core_valid_i = 1'b0, core_ready_i = 1'b0;
  logic [31:0] core_data_i = '0;
  logic [1:0]  io_valid_i = '0;
  logic        io_phase_i = 1'b0;
  logic [15:0] io_data_i = '0;
  logic [1:0]  token_i = '0;
  logic [6:0]  sent_cnt_o;
  logic [13:0] finish_cnt_o, outstanding_o;
  logic [2:0]  pending_o;
  logic [1:0]  state_o;
  logic        beat_ok_o, err_overflow_o, err_credit_o, err_data_o;
  logic        err_lockstep_o, err_timeout_o, err_any_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_link_upstream_refine_monitor #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .CREDITS(CREDITS),
    .TOKEN_DEC(TOKEN_DEC), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
    .io_valid_i(io_valid_i), .io_phase_i(io_phase_i), .io_data_i(io_data_i),
    .token_i(token_i),
    .sent_cnt_o(sent_cnt_o), .finish_cnt_o(finish_cnt_o), .outstanding_o(outstanding_o),
    .pending_o(pending_o), .state_o(state_o), .beat_ok_o(beat_ok_o),
    .err_overflow_o(err_overflow_o), .err_credit_o(err_credit_o), .err_data_o(err_data_o),
    .err_lockstep_o(err_lockstep_o), .err_timeout_o(err_timeout_o), .err_any_o(err_any_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  int          m_sent = 0;
  int          m_tok[2] = '{0, 0};
  bit          m_half = 0, m_first_ok = 0, m_beat = 0;
  int          m_wait = 0;
  bit          e_ovf = 0, e_cred = 0, e_data = 0, e_lock = 0, e_tmo = 0;

  typedef struct { int sent; int pend; } rec_t;
  rec_t sb[$];

  function automatic logic [6:0] m_out(input int c);
    return 7'(m_sent - m_tok[c]*TOKEN_DEC);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit hs, allv, cred_err, lock_err, data_err, pop, beat, tmo_err, ovf;
    logic [31:0] head;
    if (rst) begin
      m_q.delete(); sb.delete();
      m_sent = 0; m_tok[0] = 0; m_tok[1] = 0;
      m_half = 0; m_first_ok = 0; m_beat = 0; m_wait = 0;
      e_ovf = 0; e_cred = 0; e_data = 0; e_lock = 0; e_tmo = 0;
    end else begin
      hs       = core_valid_i && core_ready_i;
      allv     = (io_valid_i == 2'b11);
      lock_err = (io_valid_i != 2'b00) && !allv;
      cred_err = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs && m_out(c) == 7'(CREDITS)) cred_err = 1;
        if (token_i[c] && m_out(c) < 7'(TOKEN_DEC)) cred_err = 1;
      end
      head = (m_q.size() > 0) ? m_q[0] : 32'h0;
      data_err = 0; pop = 0; beat = 0;
      if (!m_half) begin
        if (allv) begin
          if (m_q.size() == 0 || io_phase_i) data_err = 1;
          else begin
            m_half = 1;
            m_first_ok = (io_data_i == head[15:0]);
            if (!m_first_ok) data_err = 1;
          end
        end
      end else begin
        pop = 1; m_half = 0;
        if (allv && io_phase_i) begin
          if (io_data_i == head[31:16]) beat = m_first_ok;
          else data_err = 1;
        end else data_err = 1;
      end
      // head waits are counted in whole cycles; the error fires the first cycle it exceeds MAX_LAT
      tmo_err = (m_wait == MAX_LAT + 1);
      if (pop || m_q.size() == 0) m_wait = 0;
      else m_wait++;
      ovf = 0;
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_sent++;
        if (m_q.size() >= DEPTH) ovf = 1;
        else m_q.push_back(core_data_i);
      end
      for (int c = 0; c < NUM_CH; c++) if (token_i[c]) m_tok[c]++;
      e_ovf  = (e_ovf  && !clear_i) || ovf;
      e_cred = (e_cred && !clear_i) || cred_err;
      e_data = (e_data && !clear_i) || data_err;
      e_lock = (e_lock && !clear_i) || lock_err;
      e_tmo  = (e_tmo  && !clear_i) || tmo_err;
      m_beat = beat;
      if (beat) sb.push_back('{sent: m_sent % 128, pend: m_q.size()});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("counters", {sent_cnt_o, finish_cnt_o, outstanding_o},
        {7'(m_sent), 7'(m_tok[1]*TOKEN_DEC), 7'(m_tok[0]*TOKEN_DEC), m_out(1), m_out(0)});
    chk("fifo_state", {pending_o, state_o, beat_ok_o}, {3'(m_q.size()), 1'b0, m_half, m_beat});
    chk("flags", {err_timeout_o, err_lockstep_o, err_data_o, err_credit_o, err_overflow_o, err_any_o},
        {e_tmo, e_lock, e_data, e_cred, e_ovf, (e_tmo | e_lock | e_data | e_cred | e_ovf)});
    if (beat_ok_o) begin
      if (sb.size() == 0) chk("sb_unexpected_beat", 64'd1, 64'd0);
      else begin
        rec_t r;
        r = sb.pop_front();
        chk("sb_beat", {sent_cnt_o, pending_o}, {7'(r.sent), 3'(r.pend)});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_idle();
    core_valid_i = 0; core_ready_i = 0; core_data_i = '0;
    io_valid_i = '0; io_phase_i = 0; io_data_i = '0; token_i = '0; clear_i = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    core_valid_i = 1; core_ready_i = 1; core_data_i = w;
    tick();
    core_valid_i = 0; core_ready_i = 0;
  endtask

  logic [31:0] w[6];

  initial begin
    // reset state
    do_reset();
    chk("reset_all", {sent_cnt_o, finish_cnt_o, outstanding_o, pending_o, state_o, beat_ok_o, err_any_o}, 64'd0);

    // one word, two matching half-beats
    push_word(32'h0123_4567);
    chk("t1_pending1", pending_o, 1);
    io_valid_i = 2'b11; io_phase_i = 0; io_data_i = 16'h4567; tick();
    chk("t1_state_half", state_o, 1);
    io_phase_i = 1; io_data_i = 16'h0123; tick();
    set_idle();
    chk("t1_beat_ok", beat_ok_o, 1);
    chk("t1_pending0", pending_o, 0);
    chk("t1_no_err", err_any_o, 0);
    tick();
    chk("t1_beat_pulse", beat_ok_o, 0);

    // credit exhaustion
    do_reset();
    core_valid_i = 1; core_ready_i = 1;
    repeat (64) begin core_data_i = $urandom; tick(); end
    chk("cred_out64", outstanding_o, {7'd64, 7'd64});
    chk("cred_not_yet", err_credit_o, 0);
    core_data_i = $urandom; tick();
    set_idle();
    chk("cred_err", err_credit_o, 1);
    chk("cred_sent65", sent_cnt_o, 65);

    // token returns
    do_reset();
    core_valid_i = 1; core_ready_i = 1;
    repeat (64) begin core_data_i = $urandom; tick(); end
    set_idle();
    token_i = 2'b11; tick(); token_i = '0;
    chk("tok_out56", outstanding_o, {7'd56, 7'd56});
    chk("tok_finish8", finish_cnt_o, {7'd8, 7'd8});
    chk("tok_no_cred_err", err_credit_o, 0);

    // excess token
    do_reset();
    token_i = 2'b01; tick(); token_i = '0;
    chk("xtok_err", err_credit_o, 1);
    chk("xtok_finish", finish_cnt_o, {7'd0, 7'd8});
    chk("xtok_out_wrap", outstanding_o, {7'd0, 7'd120});

    // FIFO overflow, then push and pop together on a full FIFO
    do_reset();
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push_word(w[i]);
    chk("ovf_pending4", pending_o, 4);
    chk("ovf_not_yet", err_overflow_o, 0);
    push_word(w[4]);
    chk("ovf_err", err_overflow_o, 1);
    chk("ovf_pending_stays4", pending_o, 4);
    chk("ovf_sent5", sent_cnt_o, 5);
    clear_i = 1; tick(); clear_i = 0;
    chk("ovf_cleared", err_overflow_o, 0);
    io_valid_i = 2'b11; io_phase_i = 0; io_data_i = w[0][15:0]; tick();
    io_phase_i = 1; io_data_i = w[0][31:16];
    core_valid_i = 1; core_ready_i = 1; core_data_i = w[5]; tick();
    set_idle();
    chk("full_pushpop_beat", beat_ok_o, 1);
    chk("full_pushpop_no_ovf", err_overflow_o, 0);
    chk("full_pushpop_pending", pending_o, 4);

    // lockstep and out-of-order phase
    do_reset();
    io_valid_i = 2'b01; io_data_i = $urandom; tick();
    set_idle();
    chk("lock_err", err_lockstep_o, 1);
    chk("lock_no_data_err", err_data_o, 0);
    push_word(32'hDEAD_BEEF);
    io_valid_i = 2'b11; io_phase_i = 1; io_data_i = 16'hDEAD; tick();
    set_idle();
    chk("phase1_idle_err", err_data_o, 1);
    chk("phase1_idle_state", state_o, 0);
    chk("phase1_idle_pending", pending_o, 1);

    // head latency timeout, then clear
    do_reset();
    push_word($urandom);
    repeat (11) tick();
    chk("tmo_not_yet", err_timeout_o, 0);
    tick();
    chk("tmo_err", err_timeout_o, 1);
    clear_i = 1; tick(); clear_i = 0;
    chk("tmo_clear_any", err_any_o, 0);
    chk("tmo_pending", pending_o, 1);

    // asynchronous reset while in HALF
    do_reset();
    for (int i = 0; i < 3; i++) push_word(w[i]);
    io_valid_i = 2'b11; io_phase_i = 0; io_data_i = w[0][15:0]; tick();
    set_idle();
    chk("rst_pre_state", state_o, 1);
    chk("rst_pre_pending", pending_o, 3);
    #1 rst = 1;
    #1;
    chk("rst_async_all0", {sent_cnt_o, finish_cnt_o, outstanding_o, pending_o, state_o, beat_ok_o, err_any_o}, 64'd0);
    tick(); rst = 0;
    tick();
    chk("rst_no_flag", err_any_o, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [31:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 32'h0;
      core_valid_i = ($urandom_range(0, 3) == 0);
      core_ready_i = ($urandom_range(0, 3) != 0);
      core_data_i  = $urandom;
      r = $urandom_range(0, 19);
      if (m_half && r < 17) begin
        io_valid_i = 2'b11; io_phase_i = 1;
        io_data_i = (r == 16) ? head[31:16] ^ 16'h0100 : head[31:16];
      end else if (!m_half && m_q.size() > 0 && r < 10) begin
        io_valid_i = 2'b11; io_phase_i = 0;
        io_data_i = (r == 9) ? head[15:0] ^ 16'h0001 : head[15:0];
      end else if (r >= 18) begin
        io_valid_i = 2'($urandom); io_phase_i = 1'($urandom); io_data_i = 16'($urandom);
      end else begin
        io_valid_i = 2'b00; io_phase_i = 0; io_data_i = '0;
      end
      for (int c = 0; c < NUM_CH; c++)
        token_i[c] = (m_out(c) >= 7'(TOKEN_DEC)) ? ($urandom_range(0, 7) == 0)
                                                 : ($urandom_range(0, 63) == 0);
      clear_i = ($urandom_range(0, 63) == 0);
      if (i == 750) begin
        set_idle(); rst = 1; tick(); rst = 0;
      end
      tick();
    end
    set_idle();
    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
